rsa_operand_loader: RTL and testbench

Upstream stage of the RSA decrypt datapath: it accepts a byte stream on a valid/ready interface, assembles the ciphertext, private exponent and modulus into WIDTH-bit operands, and presents a complete, validated operand set to the decrypt stage. It holds that set stable until the consumer acknowledges it. Partial frames are dropped after an inter-byte timeout, and frames with a zero modulus are rejected, so the decrypt stage never sees a truncated operand or a divide-by-zero modulus.

---
 rtl/rsa_operand_loader.sv | 146 ++++++++++++++
 tb/tb_rsa_operand_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_loader.sv
// Byte-stream loader for the RSA decrypt datapath: assembles c, d and n
// big-endian operands, rejects zero moduli and stale partial frames, and
// holds the committed set until the consumer takes it.
module rsa_operand_loader #(
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int unsigned B          = WIDTH / 8;
  localparam int unsigned CNT_W      = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(B - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {LOAD_C, LOAD_D, LOAD_N, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [WIDTH-1:0]   sh_c_q, sh_c_d, sh_d_q, sh_d_d, sh_n_q, sh_n_d;
  logic [WIDTH-1:0]   out_c_q, out_c_d, out_d_q, out_d_d, out_n_q, out_n_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic               mid_frame;
  logic               last_byte;
  logic [WIDTH-1:0]   c_asm, d_asm, n_asm;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_c     = out_c_q;
  assign out_d     = out_d_q;
  assign out_n     = out_n_q;
  assign frame_err = frame_err_q;

  assign accept    = in_valid && in_ready;
  assign last_byte = (cnt_q == LAST_BYTE);
  assign mid_frame = (state_q == LOAD_D) || (state_q == LOAD_N) ||
                     ((state_q == LOAD_C) && (cnt_q != '0));
  assign c_asm     = (sh_c_q << 8) | WIDTH'(in_data);
  assign d_asm     = (sh_d_q << 8) | WIDTH'(in_data);
  assign n_asm     = (sh_n_q << 8) | WIDTH'(in_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    sh_c_d      = sh_c_q;
    sh_d_d      = sh_d_q;
    sh_n_d      = sh_n_q;
    out_c_d     = out_c_q;
    out_d_d     = out_d_q;
    out_n_d     = out_n_q;
    frame_err_d = 1'b0;

    if (state_q == HOLD) begin
      idle_d = '0;
      if (out_ready) begin
        state_d = LOAD_C;
        cnt_d   = '0;
      end
    end else if (accept) begin
      idle_d = '0;
      cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
      case (state_q)
        LOAD_C: begin
          sh_c_d = c_asm;
          if (last_byte) state_d = LOAD_D;
        end
        LOAD_D: begin
          sh_d_d = d_asm;
          if (last_byte) state_d = LOAD_N;
        end
        default: begin
          sh_n_d = n_asm;
          if (last_byte) begin
            if (n_asm != '0) begin
              out_c_d = sh_c_q;
              out_d_d = sh_d_q;
              out_n_d = n_asm;
              state_d = HOLD;
            end else begin
              frame_err_d = 1'b1;
              state_d     = LOAD_C;
            end
          end
        end
      endcase
    end else if (mid_frame && TIMEOUT_EN) begin
      // Expiry is the idle cycle that would bring the count to TIMEOUT_CYCLES.
      if (idle_q == IDLE_LAST) begin
        state_d     = LOAD_C;
        cnt_d       = '0;
        idle_d      = '0;
        sh_c_d      = '0;
        sh_d_d      = '0;
        sh_n_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_C;
      cnt_q       <= '0;
      idle_q      <= '0;
      sh_c_q      <= '0;
      sh_d_q      <= '0;
      sh_n_q      <= '0;
      out_c_q     <= '0;
      out_d_q     <= '0;
      out_n_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      sh_c_q      <= sh_c_d;
      sh_d_q      <= sh_d_d;
      sh_n_q      <= sh_n_d;
      out_c_q     <= out_c_d;
      out_d_q     <= out_d_d;
      out_n_q     <= out_n_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader (WIDTH=128, TIMEOUT_CYCLES=16).
module tb_rsa_operand_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_c, out_d, out_n;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;

  int checks   = 0;
  int failures = 0;
  logic err_seen;

  localparam logic [127:0] C1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1 = {16{8'h11}};
  localparam logic [127:0] N1 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFB;
  localparam logic [127:0] C3 = 128'hDEADBEEF00000000000000000CAFEF0D;
  localparam logic [127:0] D3 = 128'h00000000000000000000000000010001;
  localparam logic [127:0] N3 = 128'h80000000000000000000000000000001;
  localparam logic [127:0] CZ = {16{8'h55}};
  localparam logic [127:0] DZ = {16{8'h66}};
  localparam logic [127:0] C4 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D4 = 128'd3;
  localparam logic [127:0] N4 = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] C5 = {16{8'hA5}};
  localparam logic [127:0] D5 = 128'h0000000000000000000000000000FF00;
  localparam logic [127:0] N5 = 128'd1;

  rsa_operand_loader #(.WIDTH(128), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_n     (out_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Streams bytes [first, first+count) of {c,d,n}; gapped mode inserts idle
  // cycles, including 15-cycle gaps that land an accept on the expiry cycle.
  task automatic send_bytes(input logic [383:0] frame, input int first, input int count,
                            input bit gapped);
    logic [383:0] f;
    int g;
    f = frame;
    for (int i = first; i < first + count; i++) begin
      in_data  = f[383 - 8*i -: 8];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      err_seen = err_seen | frame_err;
      if (gapped && (i < first + count - 1)) begin
        g = ((i % 7) == 3 || i == 15) ? 15 : (i % 3);
        repeat (g) begin
          @(posedge clk); #1;
          err_seen = err_seen | frame_err;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Full frame, back-to-back bytes
    send_bytes({C1, D1, N1}, 0, 47, 0);
    chk("valid_before_last", out_valid, 0);
    chk("ready_before_last", in_ready, 1);
    send_bytes({C1, D1, N1}, 47, 1, 0);
    chk("commit_valid", out_valid, 1);
    chk("commit_ready", in_ready, 0);
    chk("commit_c", out_c, C1);
    chk("commit_d", out_d, D1);
    chk("commit_n", out_n, N1);

    // Hold under back-pressure while upstream keeps offering data
    in_valid = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_c", out_c, C1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
    chk("release_c", out_c, C1);
    chk("release_n", out_n, N1);

    // Timeout after 20 bytes: pulse after the 16th idle edge only
    send_bytes({C3, D3, N3}, 0, 20, 0);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      chk("timeout_err", frame_err, (i == 16) ? 128'd1 : 128'd0);
    end
    chk("timeout_valid", out_valid, 0);
    chk("timeout_ready", in_ready, 1);
    chk("timeout_c", out_c, C1);
    chk("timeout_n", out_n, N1);
    send_bytes({C3, D3, N3}, 0, 48, 0);
    chk("after_to_valid", out_valid, 1);
    chk("after_to_c", out_c, C3);
    chk("after_to_d", out_d, D3);
    chk("after_to_n", out_n, N3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Zero modulus is rejected
    send_bytes({CZ, DZ, 128'd0}, 0, 48, 0);
    chk("zero_err", frame_err, 1);
    chk("zero_valid", out_valid, 0);
    chk("zero_ready", in_ready, 1);
    chk("zero_c", out_c, C3);
    chk("zero_n", out_n, N3);
    @(posedge clk); #1;
    chk("zero_err_clear", frame_err, 0);
    chk("zero_valid_later", out_valid, 0);

    // Asynchronous reset mid-frame, then in HOLD
    send_bytes({C1, D1, N1}, 0, 30, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_c", out_c, 0);
    chk("rst_mid_d", out_d, 0);
    chk("rst_mid_n", out_n, 0);
    chk("rst_mid_valid", out_valid, 0);
    rst = 1'b0;
    send_bytes({C4, D4, N4}, 0, 48, 0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_c", out_c, C4);
    chk("post_rst_d", out_d, D4);
    chk("post_rst_n", out_n, N4);
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_c", out_c, 0);
    chk("rst_hold_n", out_n, 0);
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_ready", in_ready, 1);
    rst = 1'b0;

    // Long idle before a frame starts, then a gapped frame with n=1
    err_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      err_seen = err_seen | frame_err;
    end
    chk("idle_start_no_err", err_seen, 0);
    send_bytes({C5, D5, N5}, 0, 48, 1);
    chk("gap_no_err", err_seen, 0);
    chk("gap_valid", out_valid, 1);
    chk("gap_c", out_c, C5);
    chk("gap_d", out_d, D5);
    chk("gap_n", out_n, N5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
